// File: rtl/sensor_init_pkg.sv
// Shared definitions for the sensor-init sequencer.
//   state_t    : sequencer FSM states
//   DELAY_REG  : register address used by delay commands (optional build)
//   END_MARKER : table word that ends the walk
package sensor_init_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWAIT,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DLY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0]  DELAY_REG  = 8'hFF;
  // The end marker is the delay register carrying data 0xFF, so it can never be
  // mistaken for a delay command.
  localparam logic [15:0] END_MARKER = {DELAY_REG, 8'hFF};

endpackage

// File: rtl/sensor_init_timer.sv
// Loadable down-counter used for the power-up wait and for ms delays.
//   clk, reset : clock, async active-high reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : start value; the counter then reaches zero load_val cycles later
//   zero       : counter is at zero (idle / expired)
module sensor_init_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sensor_init_seq.sv
// Sensor-init sequencer: walks a 512x16 pROM ({reg, data} per word) after start
// and issues one register write per entry to the SCCB master, retrying NACKs.
// Optional build macro SENSOR_INIT_DELAY_EN: entries with reg 0xFF (data != 0xFF)
// become delay commands of data*MS_CYCLES clocks instead of writes.
// Ports:
//   clk, reset            : clock, async active-high reset
//   start                 : pulse, starts from IDLE/DONE/ERR
//   rom_ad/rom_ce/rom_oce : pROM address, clock enable, output enable
//   rom_dout              : pROM word, valid one clock after rom_ce
//   req_valid/ready/addr/data : write request handshake to the master
//   xfer_done/xfer_nack   : completion pulse and its NACK qualifier
//   busy/done/error       : status; err_index = entry that exhausted retries
module sensor_init_seq
  import sensor_init_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int NUM_ENTRIES = 512,
  parameter int PWR_WAIT    = 1000000,
  parameter int MAX_RETRY   = 3,
  parameter int MS_CYCLES   = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  input  logic [15:0]       rom_dout,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [7:0]        req_addr,
  output logic [7:0]        req_data,
  input  logic              xfer_done,
  input  logic              xfer_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_index
);

`ifdef SENSOR_INIT_DELAY_EN
  localparam int DLY_MAX = 255 * MS_CYCLES;
  localparam int TW = $clog2(((PWR_WAIT > DLY_MAX) ? PWR_WAIT : DLY_MAX) + 1);
`else
  localparam int TW = $clog2(PWR_WAIT + 1);
`endif
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ENTRIES - 1);

  // Elaborates nothing for legal parameters.
  if (PWR_WAIT < 1 || MS_CYCLES < 1) begin : g_param_out_of_range
  end

  state_t          state, nxt;
  logic [ADDR_W-1:0] idx;
  logic [RW-1:0]   retry;
  logic            tmr_load, tmr_zero;
  logic [TW-1:0]   tmr_val;

  sensor_init_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) begin
        nxt      = S_PWAIT;
        tmr_load = 1'b1;
        tmr_val  = TW'(PWR_WAIT - 1);   // PWAIT lasts counts N-1..0 = N cycles
      end
      S_PWAIT: if (tmr_zero) nxt = S_FETCH;
      S_FETCH: nxt = S_LATCH;
      S_LATCH: begin
        if (rom_dout == END_MARKER) nxt = S_DONE;
`ifdef SENSOR_INIT_DELAY_EN
        else if (rom_dout[15:8] == DELAY_REG) begin
          if (rom_dout[7:0] == 8'd0) nxt = S_NEXT;
          else begin
            nxt      = S_DLY;
            tmr_load = 1'b1;
            tmr_val  = TW'(int'(rom_dout[7:0]) * MS_CYCLES - 1);
          end
        end
`endif
        else nxt = S_ISSUE;
      end
      S_ISSUE: if (req_ready) nxt = S_WAIT;
      S_WAIT: if (xfer_done) begin
        if (!xfer_nack)                  nxt = S_NEXT;
        else if (retry < RW'(MAX_RETRY)) nxt = S_ISSUE;
        else                             nxt = S_ERR;
      end
      S_NEXT: nxt = (idx == LAST) ? S_DONE : S_FETCH;
`ifdef SENSOR_INIT_DELAY_EN
      S_DLY: if (tmr_zero) nxt = S_NEXT;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      retry     <= '0;
      req_addr  <= '0;
      req_data  <= '0;
      err_index <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          idx   <= '0;
          retry <= '0;
        end
        S_LATCH: begin
          req_addr <= rom_dout[15:8];
          req_data <= rom_dout[7:0];
        end
        S_WAIT: if (xfer_done && xfer_nack) begin
          if (retry < RW'(MAX_RETRY)) retry <= retry + 1'b1;
          else                        err_index <= idx;
        end
        S_NEXT: begin
          retry <= '0;
          if (idx != LAST) idx <= idx + 1'b1;   // stop at the last entry, no wrap
        end
        default: ;
      endcase
    end
  end

  assign rom_ad    = idx;
  assign rom_ce    = (state == S_FETCH);
  assign rom_oce   = 1'b1;
  assign req_valid = (state == S_ISSUE);
  assign busy      = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);

endmodule
